// File: rtl/mem_rw_initiator.sv
// rtl/mem_rw_initiator.sv - requesting end of the byte-serial memory R/W channel
// Accepts one command, requests the controller, then streams bytes one at a time.
module mem_rw_initiator #(
    parameter int ADDR_W      = 6,
    parameter int DATA_W      = 8,
    parameter int NUM_W       = 4,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_wr,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [NUM_W-1:0]  i_cmd_num,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_wdata_valid,
    output logic              o_wdata_ready,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_rdata_valid,
    output logic              o_done,
    output logic              o_err,
    output logic              o_busy,
    output logic              o_wr_req,
    output logic              o_rd_req,
    input  logic              i_ack,
    output logic [ADDR_W-1:0] o_addr,
    output logic [NUM_W-1:0]  o_num_b,
    output logic [DATA_W-1:0] o_wr_data,
    output logic              o_wr_valid,
    input  logic              i_wr_done,
    input  logic [DATA_W-1:0] i_rd_data,
    input  logic              i_rd_valid,
    output logic              o_rd_done
);

    localparam int TO_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WDAT,
        S_RDAT,
        S_DONE,
        S_ERR
    } state_t;

    state_t state, state_nx;

    logic              alive;
    logic              dir;
    logic              full;
    logic [NUM_W-1:0]  cnt;
    logic [NUM_W-1:0]  num;
    logic [TO_W-1:0]   tcnt;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] hold;

    logic accept;
    logic wr_load;
    logic wr_step;
    logic rd_step;
    logic last;
    logic ack_expired;

    assign accept      = i_cmd_valid & o_cmd_ready;
    assign wr_load     = (state == S_WDAT) & i_wdata_valid & ~full;
    assign wr_step     = (state == S_WDAT) & i_wr_done & full;
    // o_rd_done doubles as the one-cycle blanking window between read bytes
    assign rd_step     = (state == S_RDAT) & i_rd_valid & ~o_rd_done;
    assign last        = ((cnt + NUM_W'(1)) == num);
    assign ack_expired = (tcnt == TO_W'(ACK_TIMEOUT - 1));

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        o_cmd_ready   = 1'b0;
        o_busy        = 1'b1;
        o_wr_req      = 1'b0;
        o_rd_req      = 1'b0;
        o_wdata_ready = 1'b0;
        o_wr_valid    = 1'b0;
        case (state)
            S_IDLE: begin
                o_busy      = 1'b0;
                // alive keeps ready low until the first edge after reset release
                o_cmd_ready = alive;
                if (i_cmd_valid && alive) begin
                    state_nx = (i_cmd_num == '0) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                o_wr_req = dir;
                o_rd_req = ~dir;
                if (i_ack) begin
                    state_nx = dir ? S_WDAT : S_RDAT;
                end else if (ack_expired) begin
                    state_nx = S_ERR;
                end
            end
            S_WDAT: begin
                o_wdata_ready = ~full;
                o_wr_valid    = full;
                if (wr_step && last) begin
                    state_nx = S_DONE;
                end
            end
            S_RDAT: begin
                if (rd_step && last) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            S_ERR:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign o_addr    = addr;
    assign o_num_b   = num;
    assign o_wr_data = hold;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            alive         <= 1'b0;
            dir           <= 1'b0;
            full          <= 1'b0;
            cnt           <= '0;
            num           <= '0;
            tcnt          <= '0;
            addr          <= '0;
            hold          <= '0;
            o_rdata       <= '0;
            o_rdata_valid <= 1'b0;
            o_rd_done     <= 1'b0;
            o_done        <= 1'b0;
            o_err         <= 1'b0;
        end else begin
            alive         <= 1'b1;
            o_done        <= (state == S_DONE);
            o_err         <= (state == S_ERR);
            o_rd_done     <= rd_step;
            o_rdata_valid <= rd_step;
            tcnt          <= (state == S_REQ) ? tcnt + TO_W'(1) : '0;
            if (accept) begin
                dir  <= i_cmd_wr;
                addr <= i_cmd_addr;
                num  <= i_cmd_num;
                cnt  <= '0;
            end
            if (wr_load) begin
                hold <= i_wdata;
                full <= 1'b1;
            end
            if (wr_step || rd_step) begin
                addr <= addr + ADDR_W'(1);
                cnt  <= cnt + NUM_W'(1);
            end
            if (wr_step) begin
                full <= 1'b0;
            end
            if (rd_step) begin
                o_rdata <= i_rd_data;
            end
            if (state == S_ERR) begin
                hold <= '0;
                full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_rw_initiator.sv
// tb/tb_mem_rw_initiator.sv - directed and randomized bench for mem_rw_initiator
// A transaction-level model predicts every output each cycle; directed cases pin literals.
module tb_mem_rw_initiator;

    localparam int ADDR_W      = 6;
    localparam int DATA_W      = 8;
    localparam int NUM_W       = 4;
    localparam int ACK_TIMEOUT = 15;

    logic              i_clk = 1'b0;
    logic              i_reset;
    logic              i_cmd_valid;
    logic              o_cmd_ready;
    logic              i_cmd_wr;
    logic [ADDR_W-1:0] i_cmd_addr;
    logic [NUM_W-1:0]  i_cmd_num;
    logic [DATA_W-1:0] i_wdata;
    logic              i_wdata_valid;
    logic              o_wdata_ready;
    logic [DATA_W-1:0] o_rdata;
    logic              o_rdata_valid;
    logic              o_done;
    logic              o_err;
    logic              o_busy;
    logic              o_wr_req;
    logic              o_rd_req;
    logic              i_ack;
    logic [ADDR_W-1:0] o_addr;
    logic [NUM_W-1:0]  o_num_b;
    logic [DATA_W-1:0] o_wr_data;
    logic              o_wr_valid;
    logic              i_wr_done;
    logic [DATA_W-1:0] i_rd_data;
    logic              i_rd_valid;
    logic              o_rd_done;

    mem_rw_initiator #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_W(NUM_W), .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_wr(i_cmd_wr),
        .i_cmd_addr(i_cmd_addr), .i_cmd_num(i_cmd_num),
        .i_wdata(i_wdata), .i_wdata_valid(i_wdata_valid), .o_wdata_ready(o_wdata_ready),
        .o_rdata(o_rdata), .o_rdata_valid(o_rdata_valid),
        .o_done(o_done), .o_err(o_err), .o_busy(o_busy),
        .o_wr_req(o_wr_req), .o_rd_req(o_rd_req), .i_ack(i_ack),
        .o_addr(o_addr), .o_num_b(o_num_b), .o_wr_data(o_wr_data), .o_wr_valid(o_wr_valid),
        .i_wr_done(i_wr_done), .i_rd_data(i_rd_data), .i_rd_valid(i_rd_valid),
        .o_rd_done(o_rd_done)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    localparam int PH_IDLE = 0, PH_WAIT_ACK = 1, PH_MOVE = 2, PH_FINISH = 3, PH_FAIL = 4;
    int m_phase, m_base, m_count, m_num, m_waited, m_hold, m_rdata;
    bit m_alive, m_wr, m_full, m_rvalid, m_rdone, m_done, m_err;

    int wlog_addr[$];
    int wlog_data[$];
    int rlog[$];
    int done_cnt = 0, err_cnt = 0, req_cycles = 0, accept_cyc = 0, done_cyc = 0;
    int dbytes[16];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_phase = PH_IDLE; m_base = 0; m_count = 0; m_num = 0; m_waited = 0;
        m_hold = 0; m_rdata = 0; m_alive = 0; m_wr = 0; m_full = 0;
        m_rvalid = 0; m_rdone = 0; m_done = 0; m_err = 0;
    endtask

    // Advance the model by one clock using the inputs the DUT will sample next edge.
    task automatic model_step();
        int  nphase;
        bit  take_rd;
        nphase  = m_phase;
        take_rd = (m_phase == PH_MOVE) && !m_wr && i_rd_valid && !m_rdone;
        m_done  = (m_phase == PH_FINISH);
        m_err   = (m_phase == PH_FAIL);
        case (m_phase)
            PH_IDLE: if (i_cmd_valid && m_alive) begin
                m_wr = i_cmd_wr; m_base = int'(i_cmd_addr); m_num = int'(i_cmd_num);
                m_count = 0; m_waited = 0;
                nphase = (m_num == 0) ? PH_FINISH : PH_WAIT_ACK;
            end
            PH_WAIT_ACK: begin
                if (i_ack) nphase = PH_MOVE;
                else if (m_waited + 1 == ACK_TIMEOUT) nphase = PH_FAIL;
                else m_waited++;
            end
            PH_MOVE: begin
                if (m_wr) begin
                    if (i_wdata_valid && !m_full) begin
                        m_hold = int'(i_wdata); m_full = 1;
                    end else if (i_wr_done && m_full) begin
                        m_full = 0; m_count++;
                        if (m_count == m_num) nphase = PH_FINISH;
                    end
                end else if (take_rd) begin
                    m_rdata = int'(i_rd_data); m_count++;
                    if (m_count == m_num) nphase = PH_FINISH;
                end
            end
            PH_FAIL: begin m_hold = 0; m_full = 0; nphase = PH_IDLE; end
            default: nphase = PH_IDLE;
        endcase
        m_rvalid = take_rd;
        m_rdone  = take_rd;
        m_alive  = 1;
        m_phase  = nphase;
    endtask

    task automatic check_cycle();
        cyc++;
        if (!i_reset) model_reset();
        chk("cmd_ready",   int'(o_cmd_ready),   int'(m_alive && m_phase == PH_IDLE));
        chk("busy",        int'(o_busy),        int'(m_phase != PH_IDLE));
        chk("wr_req",      int'(o_wr_req),      int'(m_phase == PH_WAIT_ACK && m_wr));
        chk("rd_req",      int'(o_rd_req),      int'(m_phase == PH_WAIT_ACK && !m_wr));
        chk("addr",        int'(o_addr),        (m_base + m_count) % (1 << ADDR_W));
        chk("num_b",       int'(o_num_b),       m_num);
        chk("wdata_ready", int'(o_wdata_ready), int'(m_phase == PH_MOVE && m_wr && !m_full));
        chk("wr_valid",    int'(o_wr_valid),    int'(m_phase == PH_MOVE && m_wr && m_full));
        chk("wr_data",     int'(o_wr_data),     m_hold);
        chk("rdata",       int'(o_rdata),       m_rdata);
        chk("rdata_valid", int'(o_rdata_valid), int'(m_rvalid));
        chk("rd_done",     int'(o_rd_done),     int'(m_rdone));
        chk("done",        int'(o_done),        int'(m_done));
        chk("err",         int'(o_err),         int'(m_err));
        if (i_reset && o_wr_valid && i_wr_done) begin
            wlog_addr.push_back(int'(o_addr));
            wlog_data.push_back(int'(o_wr_data));
        end
        if (o_rdata_valid) rlog.push_back(int'(o_rdata));
        if (o_done) begin done_cnt++; done_cyc = cyc; end
        if (o_err) err_cnt++;
        if (o_wr_req || o_rd_req) req_cycles++;
        if (i_reset && i_cmd_valid && o_cmd_ready) accept_cyc = cyc;
        if (i_reset) model_step();
    endtask

    task automatic tick();
        @(negedge i_clk);
        check_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_cmd_valid = 0; i_cmd_wr = 0; i_cmd_addr = '0; i_cmd_num = '0;
        i_wdata = '0; i_wdata_valid = 0; i_ack = 0; i_wr_done = 0;
        i_rd_data = '0; i_rd_valid = 0;
    endtask

    // Drives one command and plays the controller/upstream roles until done or err.
    task automatic run_cmd(input bit wr, input int addr, input int num, input int ack_delay,
                           input bit stray, input int rst_after);
        int wsent, rgot, reqc, wl0;
        bit wv_prev, finished, was_reset;
        wsent = 0; rgot = 0; reqc = 0; wv_prev = 0; finished = 0; was_reset = 0;
        wl0 = wlog_addr.size();
        i_cmd_valid = 1; i_cmd_wr = wr;
        i_cmd_addr = ADDR_W'(addr); i_cmd_num = NUM_W'(num);
        for (int k = 0; k < 80; k++) begin
            tick();
            if (o_busy) i_cmd_valid = 0;
            if (o_done || o_err) begin finished = 1; break; end
            if (rst_after > 0 && (wlog_addr.size() - wl0) >= rst_after) begin
                was_reset = 1; finished = 1; break;
            end
            if (o_wr_req || o_rd_req) reqc++;
            i_ack = (ack_delay >= 0) && (o_wr_req || o_rd_req) && (reqc >= ack_delay);
            i_wdata_valid = wr && o_wdata_ready && (wsent < num);
            if (i_wdata_valid) begin
                i_wdata = DATA_W'(dbytes[wsent]);
                wsent++;
            end
            i_wr_done = (o_wr_valid && wv_prev) || (stray && !o_wr_valid);
            wv_prev = o_wr_valid;
            if (o_rd_done) rgot++;
            i_rd_valid = !wr && (rgot < num);
            i_rd_data = DATA_W'(dbytes[rgot % 16]);
        end
        chk("cmd_finished", int'(finished), 1);
        idle_inputs();
        if (was_reset) begin
            i_reset = 0;
            #1;
            chk("rst_busy",     int'(o_busy),      0);
            chk("rst_wr_valid", int'(o_wr_valid),  0);
            chk("rst_addr",     int'(o_addr),      0);
            chk("rst_num_b",    int'(o_num_b),     0);
            chk("rst_ready",    int'(o_cmd_ready), 0);
            chk("rst_wr_data",  int'(o_wr_data),   0);
            tick();
            tick();
            i_reset = 1;
        end
        tick();
    endtask

    initial begin
        int d0, e0, w0, r0, q0;
        i_reset = 0;
        idle_inputs();
        repeat (3) tick();
        chk("reset_ready", int'(o_cmd_ready), 0);
        chk("reset_busy",  int'(o_busy),      0);
        chk("reset_addr",  int'(o_addr),      0);
        i_reset = 1;
        tick();
        chk("ready_after_release", int'(o_cmd_ready), 1);

        // write 3 bytes at 5
        dbytes[0] = 'hA1; dbytes[1] = 'hB2; dbytes[2] = 'hC3;
        d0 = done_cnt; w0 = wlog_addr.size(); q0 = req_cycles;
        run_cmd(1, 5, 3, 2, 0, 0);
        chk("w3_count", wlog_addr.size() - w0, 3);
        if (wlog_addr.size() - w0 == 3) begin
            chk("w3_addr0", wlog_addr[w0],     5);
            chk("w3_addr1", wlog_addr[w0 + 1], 6);
            chk("w3_addr2", wlog_addr[w0 + 2], 7);
            chk("w3_data0", wlog_data[w0],     'hA1);
            chk("w3_data1", wlog_data[w0 + 1], 'hB2);
            chk("w3_data2", wlog_data[w0 + 2], 'hC3);
        end
        chk("w3_done", done_cnt - d0, 1);
        chk("w3_req_cycles", req_cycles - q0, 2);
        chk("w3_busy_after", int'(o_busy), 0);

        // read 2 bytes at 10
        dbytes[0] = 'h5A; dbytes[1] = 'h6B;
        d0 = done_cnt; r0 = rlog.size();
        run_cmd(0, 10, 2, 1, 0, 0);
        chk("r2_count", rlog.size() - r0, 2);
        if (rlog.size() - r0 == 2) begin
            chk("r2_data0", rlog[r0],     'h5A);
            chk("r2_data1", rlog[r0 + 1], 'h6B);
        end
        chk("r2_done", done_cnt - d0, 1);
        chk("r2_addr_end", int'(o_addr), 12);

        // zero-length command
        d0 = done_cnt; q0 = req_cycles;
        run_cmd(1, 33, 0, 1, 0, 0);
        chk("z_req_cycles", req_cycles - q0, 0);
        chk("z_done", done_cnt - d0, 1);
        chk("z_latency", done_cyc - accept_cyc, 2);

        // ack never arrives; spurious wr_done meanwhile
        d0 = done_cnt; e0 = err_cnt; q0 = req_cycles;
        run_cmd(1, 20, 3, -1, 1, 0);
        chk("to_err", err_cnt - e0, 1);
        chk("to_no_done", done_cnt - d0, 0);
        chk("to_req_cycles", req_cycles - q0, ACK_TIMEOUT);
        chk("to_ready", int'(o_cmd_ready), 1);
        chk("to_req_low", int'(o_wr_req), 0);
        chk("to_addr", int'(o_addr), 20);

        // wrap at top of address space with stray wr_done
        dbytes[0] = 'h11; dbytes[1] = 'h22;
        d0 = done_cnt; w0 = wlog_addr.size();
        run_cmd(1, 63, 2, 3, 1, 0);
        chk("wrap_count", wlog_addr.size() - w0, 2);
        if (wlog_addr.size() - w0 == 2) begin
            chk("wrap_addr0", wlog_addr[w0],     63);
            chk("wrap_addr1", wlog_addr[w0 + 1], 0);
            chk("wrap_data1", wlog_data[w0 + 1], 'h22);
        end
        chk("wrap_done", done_cnt - d0, 1);
        chk("wrap_addr_end", int'(o_addr), 1);

        // reset after first of four bytes, then a fresh read
        dbytes[0] = 'h01; dbytes[1] = 'h02; dbytes[2] = 'h03; dbytes[3] = 'h04;
        d0 = done_cnt; e0 = err_cnt;
        run_cmd(1, 30, 4, 1, 0, 1);
        chk("rst_no_done", done_cnt - d0, 0);
        chk("rst_no_err", err_cnt - e0, 0);
        dbytes[0] = 'h77;
        d0 = done_cnt; r0 = rlog.size();
        run_cmd(0, 40, 1, 2, 0, 0);
        chk("fresh_done", done_cnt - d0, 1);
        chk("fresh_rcount", rlog.size() - r0, 1);
        if (rlog.size() - r0 == 1) chk("fresh_rdata", rlog[r0], 'h77);

        // randomized traffic with occasional async reset
        for (int k = 0; k < 3000; k++) begin
            i_reset       = ($urandom_range(0, 299) != 0);
            i_cmd_valid   = ($urandom_range(0, 2) == 0);
            i_cmd_wr      = 1'($urandom);
            i_cmd_addr    = ADDR_W'($urandom);
            i_cmd_num     = ($urandom_range(0, 2) == 0) ? NUM_W'($urandom) : NUM_W'($urandom_range(0, 3));
            i_ack         = ($urandom_range(0, 3) == 0);
            i_wdata       = DATA_W'($urandom);
            i_wdata_valid = 1'($urandom);
            i_wr_done     = 1'($urandom);
            i_rd_data     = DATA_W'($urandom);
            i_rd_valid    = 1'($urandom);
            tick();
        end
        i_reset = 1;
        idle_inputs();
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d errors so far", n_errors);
        $fatal(1);
    end

endmodule

// File: doc/mem_rw_initiator.md
Name: mem_rw_initiator

Overview:
- Requesting end of the byte-serial memory R/W channel: accepts one upstream command (read or write, base address, byte count) and drives the memory controller's request/ack, address, byte-count and per-byte handshakes.
- Sits between a command source (sequencer/bus bridge) and the shared 64-byte memory controller.
- Streams write bytes in from upstream and returns read bytes as single-cycle pulses.

Parameters:
ADDR_W, 6, memory address width; address wraps modulo 2^ADDR_W
DATA_W, 8, byte/data width
NUM_W, 4, byte-count width (0..15 bytes per command)
ACK_TIMEOUT, 15, cycles to wait in REQ for i_ack before abort

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous active-low reset
i_cmd_valid  in  1  command present
o_cmd_ready  out  1  high in IDLE only; command accepted on i_cmd_valid & o_cmd_ready
i_cmd_wr  in  1  1 = write, 0 = read
i_cmd_addr  in  ADDR_W  base address
i_cmd_num  in  NUM_W  byte count
i_wdata  in  DATA_W  upstream write byte
i_wdata_valid  in  1  write byte present
o_wdata_ready  out  1  holding register empty and state WDAT
o_rdata  out  DATA_W  captured read byte
o_rdata_valid  out  1  one-cycle pulse per read byte
o_done  out  1  one-cycle pulse at command completion
o_err  out  1  one-cycle pulse on ack timeout
o_busy  out  1  state != IDLE
o_wr_req  out  1  write request to controller
o_rd_req  out  1  read request to controller
i_ack  in  1  controller acknowledge
o_addr  out  ADDR_W  current byte address
o_num_b  out  NUM_W  latched byte count
o_wr_data  out  DATA_W  holding-register byte
o_wr_valid  out  1  holding register full (WDAT only)
i_wr_done  in  1  controller wrote current byte
i_rd_data  in  DATA_W  controller read byte
i_rd_valid  in  1  controller read byte valid
o_rd_done  out  1  one-cycle pulse: byte consumed

Behaviour:
- Reset (async, i_reset low): state IDLE; all outputs, counters and holding register 0; o_cmd_ready goes to 1 once in IDLE after reset release. Reset mid-command abandons it with no o_done/o_err.
- States: IDLE, REQ, WDAT, RDAT, DONE, ERR.
- IDLE: on accept, latch dir, addr, num; byte count cnt = 0.
  - num = 0: go to DONE, no request issued.
  - else: go to REQ.
- REQ:
  - o_wr_req or o_rd_req held high per dir; o_addr = base; o_num_b = num.
  - On i_ack: drop req next cycle; go to WDAT (write) or RDAT (read).
  - Timeout counter starts at 0 on REQ entry. If i_ack is not seen after ACK_TIMEOUT cycles: go to ERR.
- WDAT:
  - o_wdata_ready = ~full. i_wdata_valid & o_wdata_ready loads the holding register and sets full.
  - o_wr_valid = full.
  - i_wr_done & full: clear full; o_addr += 1; cnt += 1.
  - Simultaneous load and i_wr_done are impossible, since ready requires ~full.
  - i_wr_done while ~full is ignored.
  - When cnt reaches num: go to DONE.
- RDAT:
  - Byte accepted when i_rd_valid & ~o_rd_done. On accept:
    - o_rdata <= i_rd_data; o_rdata_valid pulses next cycle.
    - o_rd_done pulses 1 cycle; o_addr += 1; cnt += 1.
  - i_rd_valid is ignored during the o_rd_done cycle, giving a maximum rate of 1 byte per 2 cycles.
  - When cnt reaches num: go to DONE.
- DONE: o_done = 1 for one cycle, then IDLE.
- ERR: o_err = 1 for one cycle, then IDLE. The holding register is cleared.
- Arithmetic:
  - o_addr increments modulo 2^ADDR_W (63 -> 0).
  - cnt is NUM_W bits; the compare is cnt == num, so no overflow is possible.
- o_num_b and dir hold stable from accept until DONE/ERR.
- i_ack outside REQ is ignored. Write/read handshakes outside WDAT/RDAT are ignored.

Test Plan:
- Write of 3 bytes to addr 5 with data A1, B2, C3; controller acks after 2 cycles and pulses i_wr_done 1 cycle after each o_wr_valid -> o_addr steps 5, 6, 7; o_wr_data A1, B2, C3; one o_done pulse; o_busy drops after it.
- Read of 2 bytes from addr 10 returning 5A, 6B -> o_rdata_valid pulses with 5A then 6B; o_rd_done pulses twice; i_rd_valid held high through the pulse cycle counts only once per byte; o_done pulses.
- Command with num = 0 -> no o_wr_req/o_rd_req; o_done pulses 2 cycles after accept.
- No i_ack for 15 cycles -> o_err pulses once, req drops, returns to IDLE and o_cmd_ready = 1; a spurious i_wr_done during REQ has no effect.
- Write of 2 bytes at addr 63 -> o_addr 63 then 0; stray i_wr_done while o_wr_valid = 0 does not advance cnt.
- Assert i_reset low after the 1st of 4 write bytes -> all outputs 0 immediately; no o_done; a fresh command after release is accepted normally.
